// File: rtl/pc_gshare_predictor.sv
// Fetch PC generator with a gshare predictor: tagged BTB plus a PHT of
// saturating counters indexed by PC XOR global history.
module pc_gshare_predictor #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         IDX_W    = 7,
  parameter int unsigned         TAG_W    = 9,
  parameter int unsigned         GHR_W    = 4,
  parameter int unsigned         CTR_W    = 2,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall_enable,
  input  logic              jump_enable_i,
  input  logic [ADDR_W-1:0] jump_pc_i,
  input  logic              is_branch_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              icache_hitted_i,
  input  logic              inst_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_jump_enable_o,
  output logic              pred_taken_o
);

  localparam int unsigned      DEPTH    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic [ADDR_W-1:0] r_pc;
  logic [GHR_W-1:0]  r_ghr;
  logic [ADDR_W-1:0] r_btb [DEPTH];
  logic [TAG_W-1:0]  r_tag [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [CTR_W-1:0]  r_pht [DEPTH];

  logic [IDX_W-1:0]  w_lk_idx;
  logic [IDX_W-1:0]  w_up_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic [TAG_W-1:0]  w_up_tag;
  logic              w_pred_hit;
  logic              w_jump_accept;
  logic              w_advance;
  logic              w_fb_we;
  logic [CTR_W-1:0]  w_ctr_cur;
  logic [CTR_W-1:0]  w_ctr_next;
  logic [GHR_W-1:0]  w_ghr_next;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_unused_bits;

  assign w_lk_idx = r_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
  assign w_up_idx = branch_pc_i[IDX_W+1:2] ^ IDX_W'(r_ghr);
  assign w_lk_tag = r_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_up_tag = branch_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign w_unused_bits = ^{branch_pc_i, r_pc};

  assign w_pred_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag) &&
                      r_pht[w_lk_idx][CTR_W-1];

  assign pc_o             = r_pc;
  assign pred_taken_o     = w_pred_hit && !rst;
  assign w_jump_accept    = jump_enable_i && (icache_hitted_i || !inst_ready_i);
  assign pc_jump_enable_o = w_jump_accept && !rst;
  assign w_advance        = !stall_enable && (inst_ready_i || icache_hitted_i);
  assign w_fb_we          = rdy && is_branch_i && !rst;

  always_comb begin
    w_pc_next = r_pc;
    if (w_jump_accept) begin
      w_pc_next = jump_pc_i;
    end else if (w_advance && w_pred_hit) begin
      w_pc_next = r_btb[w_lk_idx];
    end else if (w_advance) begin
      w_pc_next = r_pc + ADDR_W'(4);
    end
  end

  always_comb begin
    w_ctr_cur  = r_pht[w_up_idx];
    w_ctr_next = w_ctr_cur;
    if (branch_taken_i) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + CTR_W'(1);
    end else begin
      if (w_ctr_cur != '0) w_ctr_next = w_ctr_cur - CTR_W'(1);
    end
  end

  // A one-bit history has no older bits to shift, so it simply tracks the last outcome.
  generate
    if (GHR_W == 1) begin : g_ghr1
      assign w_ghr_next = branch_taken_i;
    end else begin : g_ghrn
      assign w_ghr_next = {r_ghr[GHR_W-2:0], branch_taken_i};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_PC;
      r_ghr <= '0;
    end else if (rdy) begin
      r_pc <= w_pc_next;
      if (is_branch_i) r_ghr <= w_ghr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_pht[i] <= CTR_INIT;
    end else if (w_fb_we) begin
      r_valid[w_up_idx] <= 1'b1;
      r_pht[w_up_idx]   <= w_ctr_next;
    end
  end

  // Target and tag storage needs no reset: entries are qualified by r_valid.
  always_ff @(posedge clk) begin
    if (w_fb_we) begin
      r_btb[w_up_idx] <= branch_target_i;
      r_tag[w_up_idx] <= w_up_tag;
    end
  end

endmodule
